mem_bus_ctrl: RTL

// - Memory-side stage downstream of control: turns mem_rd/mem_wr into a req/ack bus transaction with wait states.
// - Address comes from MAR and write data from MDR; read data returns to MDR.
// - Drives stall back to control while a transaction is in flight.

---
 rtl/mem_bus_ctrl_pkg.sv | 20 ++
 rtl/mem_bus_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared CPU definitions for the memory bus stage: FSM state encoding,
// default bus widths and a request-decode helper.
package mem_bus_ctrl_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_e;

  // Exactly one of read/write: a legal request from control.
  function automatic logic single_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Memory bus stage: turns mem_rd/mem_wr into a req/ack bus transfer and stalls control meanwhile.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that aborts to ERR after TIMEOUT cycles without bus_ack.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ld_mdr_mem,
  output logic              stall,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  mem_state_e state_q, state_d;

  logic accept;      // legal request taken in IDLE
  logic illegal;     // simultaneous read and write
  logic ack_done;    // bus_ack completing the transfer in BUSY
  logic stray_ack;   // bus_ack seen when no transfer is pending

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;

  // cnt_inc is the number of BUSY cycles elapsed including the current one.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (state_q == BUSY) && !bus_ack && (cnt_inc == CNT_W'(TIMEOUT));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    accept    = 1'b0;
    illegal   = 1'b0;
    ack_done  = 1'b0;
    stray_ack = bus_ack && (state_q != BUSY);
    unique case (state_q)
      IDLE: begin
        if (mem_rd && mem_wr) begin
          illegal = 1'b1;
          state_d = ERR;
        end else if (single_req(mem_rd, mem_wr)) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timed_out) begin
          state_d = ERR;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall only while a legal request waits in IDLE or a transfer is in flight.
  assign stall = ((state_q == IDLE) && single_req(mem_rd, mem_wr)) || (state_q == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      ld_mdr_mem <= 1'b0;
      fault      <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      ld_mdr_mem <= 1'b0;
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_wr;
        bus_addr  <= addr;
        bus_wdata <= wdata;
      end
      if (ack_done) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          rdata      <= bus_rdata;
          ld_mdr_mem <= 1'b1;
        end
      end
      if (illegal || stray_ack) begin
        fault <= 1'b1;
      end
`ifdef MEM_TIMEOUT_EN
      if (timed_out) begin
        bus_req <= 1'b0;
        fault   <= 1'b1;
      end
`endif
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == BUSY && !bus_ack) begin
      cnt_q <= cnt_inc;
    end
  end
`endif

endmodule
